// File: rtl/fsm_c.sv
// Moore serial detector for the bit pattern 1,1,0,1 with overlapping matches.
// The detect flag Y is registered alongside the state, so it has no path from E.
module fsm_c (
  input  logic CLK,
  input  logic E,
  input  logic RST,
  output logic Y
);

  typedef enum logic [2:0] {
    S0    = 3'd0,
    S1    = 3'd1,
    S11   = 3'd2,
    S110  = 3'd3,
    S1101 = 3'd4
  } state_e;

  state_e state_q, state_d;
  logic   y_q, y_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S0;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
    end
  end

  // Unused codes fall through to S0 via the default.
  always_comb begin
    state_d = S0;
    case (state_q)
      S0:      state_d = E ? S1    : S0;
      S1:      state_d = E ? S11   : S0;
      S11:     state_d = E ? S11   : S110;
      S110:    state_d = E ? S1101 : S0;
      S1101:   state_d = E ? S11   : S0;
      default: state_d = S0;
    endcase
    y_d = (state_d == S1101);
  end

  assign Y = y_q;

endmodule

// File: tb/tb_fsm_c.sv
// Bench for fsm_c: directed vector table, then random bits against a history-based model.
module tb_fsm_c;

  logic CLK = 1'b0;
  logic E   = 1'b0;
  logic RST = 1'b0;
  logic Y;

  int checks = 0;
  int passed = 0;

  fsm_c dut (
    .CLK (CLK),
    .E   (E),
    .RST (RST),
    .Y   (Y)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic rst;
    logic e;
    logic y;
    string name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic e, input logic y, input string name);
    vec_t v;
    v.rst = rst; v.e = e; v.y = y; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: Y=%b expected %b at t=%0t", name, act, exp, $time);
  endtask

  // Apply one cycle of inputs and return Y sampled just after the edge.
  task automatic step(input logic rst, input logic e, output logic y);
    RST = rst;
    E   = e;
    @(posedge CLK);
    #1;
    y = Y;
  endtask

  // Reference: Y is high exactly when the last four bits seen since reset are 1,1,0,1.
  logic [3:0] hist;
  int         nbits;

  function automatic logic model_step(input logic rst, input logic e);
    if (rst) begin
      hist  = 4'b0;
      nbits = 0;
      return 1'b0;
    end
    hist  = {hist[2:0], e};
    nbits = nbits + 1;
    return (nbits >= 4) && (hist == 4'b1101);
  endfunction

  initial begin
    logic y, prev_y, exp;

    // Reset with E=1 for two edges
    add(1, 1, 0, "reset0"); add(1, 1, 0, "reset1");
    // Basic match then E=0
    add(0, 1, 0, "basic1"); add(0, 1, 0, "basic2"); add(0, 0, 0, "basic3");
    add(0, 1, 1, "basic4"); add(0, 0, 0, "basic_drop");
    // Overlap 1101101
    add(0, 1, 0, "ovl1"); add(0, 1, 0, "ovl2"); add(0, 0, 0, "ovl3"); add(0, 1, 1, "ovl4");
    add(0, 1, 0, "ovl5"); add(0, 0, 0, "ovl6"); add(0, 1, 1, "ovl7"); add(0, 0, 0, "ovl_drop");
    // Long run of ones 111101
    add(0, 1, 0, "ones1"); add(0, 1, 0, "ones2"); add(0, 1, 0, "ones3"); add(0, 1, 0, "ones4");
    add(0, 0, 0, "ones5"); add(0, 1, 1, "ones6"); add(0, 0, 0, "ones_drop");
    // Near-miss 1100101
    add(0, 1, 0, "near1"); add(0, 1, 0, "near2"); add(0, 0, 0, "near3"); add(0, 0, 0, "near4");
    add(0, 1, 0, "near5"); add(0, 0, 0, "near6"); add(0, 1, 0, "near7"); add(0, 0, 0, "near8");
    // Reset mid-pattern while E=1 would have completed the match
    add(0, 1, 0, "mid1"); add(0, 1, 0, "mid2"); add(0, 0, 0, "mid3");
    add(1, 1, 0, "mid_rst_prio");
    add(0, 1, 0, "post1"); add(0, 1, 0, "post2"); add(0, 0, 0, "post3"); add(0, 1, 1, "post4");
    // History discarded: 1,1 then reset then 0,1 must not match
    add(0, 1, 0, "hist1"); add(0, 1, 0, "hist2"); add(1, 0, 0, "hist_rst");
    add(0, 0, 0, "hist3"); add(0, 1, 0, "hist4");

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].e, y);
      check(vecs[i].name, y, vecs[i].y);
    end

    // Random stimulus against the history model
    step(1, 0, y);
    void'(model_step(1, 0));
    check("rand_reset", y, 1'b0);
    prev_y = 1'b0;
    for (int i = 0; i < 600; i++) begin
      logic r, b;
      r = ($urandom_range(0, 39) == 0);
      b = ($urandom_range(0, 3) != 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
      b = (i % 3 == 0) ? $urandom_range(0, 1) : b;
      step(r, b, y);
      exp = model_step(r, b);
      check("rand", y, exp);
      if (prev_y && y) check("no_double_pulse", y, 1'b0);
      prev_y = y;
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
